// File: rtl/apb_reg_slave.sv
// apb_reg_slave
// APB completer exposing NUM_REGS 32-bit read/write registers to a peripheral.
// The setup phase latches the request. WAIT_STATES wait cycles are inserted in
// the access phase, then the transfer completes with pready.
//
// Ports:
//   s_apb_pclk_i     APB clock (only clock)
//   s_apb_presetn_i  asynchronous active-low reset
//   s_apb_psel_i     completer select
//   s_apb_penable_i  access phase
//   s_apb_pwrite_i   1 = write, 0 = read
//   s_apb_paddr_i    byte address
//   s_apb_pwdata_i   write data
//   s_apb_prdata_o   read data, zero except while pready is high
//   s_apb_pready_o   transfer complete
//   s_apb_pslverr_o  transfer error on an invalid request
//   regs_o           flattened register bank; reg i is at [32i+31:32i]
//   wr_pulse_o       one-cycle strobe per register, in the cycle after commit
//
// Optional feature:
//   APB_REG_SLAVE_SLVERR_EN  when defined, an invalid request drives pslverr
//                            during its completion cycle. Otherwise pslverr is 0.
module apb_reg_slave #(
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 1,
  parameter int APB_AW      = 32,
  parameter int APB_DW      = 32
) (
  input  logic                       s_apb_pclk_i,
  input  logic                       s_apb_presetn_i,
  input  logic                       s_apb_psel_i,
  input  logic                       s_apb_penable_i,
  input  logic                       s_apb_pwrite_i,
  input  logic [APB_AW-1:0]          s_apb_paddr_i,
  input  logic [APB_DW-1:0]          s_apb_pwdata_i,
  output logic [APB_DW-1:0]          s_apb_prdata_o,
  output logic                       s_apb_pready_o,
  output logic                       s_apb_pslverr_o,
  output logic [NUM_REGS*APB_DW-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  localparam int         IDXW = $clog2(NUM_REGS);
  localparam logic [3:0] WS   = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic [APB_AW-1:0]   addr_q;
  logic                write_q;
  logic [APB_DW-1:0]   wdata_q;
  logic [APB_DW-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q;
  logic [NUM_REGS-1:0] wr_pulse_d;

  logic [IDXW-1:0]     idx;
  logic                req_valid;
  logic                pready;
  logic                commit_wr;

  // Decode works on the latched address, so it is stable through the access phase.
  assign idx       = addr_q[IDXW+1:2];
  assign req_valid = (addr_q[1:0] == 2'b00) && ((addr_q >> (IDXW + 2)) == '0);

  assign pready    = (state_q == ACCESS) && (cnt_q == 4'd0) &&
                     s_apb_psel_i && s_apb_penable_i;
  assign commit_wr = pready && write_q && req_valid;

  // FSM: IDLE accepts a setup phase; ACCESS counts wait states and then completes.
  // Dropping psel in ACCESS aborts the transfer without committing it.
  always_ff @(posedge s_apb_pclk_i or negedge s_apb_presetn_i) begin
    if (!s_apb_presetn_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_apb_psel_i && !s_apb_penable_i) begin
            addr_q  <= s_apb_paddr_i;
            write_q <= s_apb_pwrite_i;
            wdata_q <= s_apb_pwdata_i;
            cnt_q   <= WS;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!s_apb_psel_i) begin
            state_q <= IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (s_apb_penable_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    wr_pulse_d = '0;
    if (commit_wr) wr_pulse_d[idx] = 1'b1;
  end

  always_ff @(posedge s_apb_pclk_i or negedge s_apb_presetn_i) begin
    if (!s_apb_presetn_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_pulse_q <= '0;
    end else begin
      if (commit_wr) regs_q[idx] <= wdata_q;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*APB_DW +: APB_DW] = regs_q[g];
  end

  assign wr_pulse_o     = wr_pulse_q;
  assign s_apb_pready_o = pready;
  assign s_apb_prdata_o = (pready && req_valid) ? regs_q[idx] : '0;

`ifdef APB_REG_SLAVE_SLVERR_EN
  assign s_apb_pslverr_o = pready && !req_valid;
`else
  assign s_apb_pslverr_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_slave.sv
// Testbench for apb_reg_slave. Two instances share the APB bus, one with
// WAIT_STATES=0 and one with WAIT_STATES=3, and each has its own psel.
// The driver pushes the expected completion of each transfer into a
// per-instance queue. The monitor pops an entry whenever pready is seen and
// checks the strobe and register bank in the following cycle.
module tb_apb_reg_slave;

`ifdef APB_REG_SLAVE_SLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;

  logic [31:0]  prdata0, prdata1;
  logic         pready0, pready1, perr0, perr1;
  logic [255:0] regs0, regs1;
  logic [7:0]   wrp0, wrp1;

  always #5 clk = ~clk;

  apb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(0), .APB_AW(32), .APB_DW(32)) u_ws0 (
    .s_apb_pclk_i(clk), .s_apb_presetn_i(rst_n), .s_apb_psel_i(psel[0]),
    .s_apb_penable_i(penable), .s_apb_pwrite_i(pwrite), .s_apb_paddr_i(paddr),
    .s_apb_pwdata_i(pwdata), .s_apb_prdata_o(prdata0), .s_apb_pready_o(pready0),
    .s_apb_pslverr_o(perr0), .regs_o(regs0), .wr_pulse_o(wrp0));

  apb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(3), .APB_AW(32), .APB_DW(32)) u_ws3 (
    .s_apb_pclk_i(clk), .s_apb_presetn_i(rst_n), .s_apb_psel_i(psel[1]),
    .s_apb_penable_i(penable), .s_apb_pwrite_i(pwrite), .s_apb_paddr_i(paddr),
    .s_apb_pwdata_i(pwdata), .s_apb_prdata_o(prdata1), .s_apb_pready_o(pready1),
    .s_apb_pslverr_o(perr1), .regs_o(regs1), .wr_pulse_o(wrp1));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  strobe;
    logic [31:0] wdata;
    int          idx;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_setup = 0;

  logic [7:0]  pend_strb [2] = '{8'h00, 8'h00};
  logic [31:0] pend_data [2] = '{32'h0, 32'h0};
  int          pend_idx  [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor for one instance, run at every falling edge.
  task automatic mon(input int d);
    exp_t         e;
    logic [7:0]   w;
    logic         rdy, err;
    logic [31:0]  rd;
    logic [255:0] r;
    w   = d ? wrp1 : wrp0;
    rdy = d ? pready1 : pready0;
    err = d ? perr1 : perr0;
    rd  = d ? prdata1 : prdata0;
    r   = d ? regs1 : regs0;
    if (w != 8'h00 || pend_strb[d] != 8'h00) begin
      chk("wr_pulse", 256'(w), 256'(pend_strb[d]));
      if (pend_strb[d] != 8'h00)
        chk("regs_at_strobe", 256'(r[pend_idx[d]*32 +: 32]), 256'(pend_data[d]));
    end
    pend_strb[d] = 8'h00;
    if (rdy) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        chk("unexpected_pready", 256'(rdy), 256'(0));
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk("prdata", 256'(rd), 256'(e.rdata));
        chk("pslverr", 256'(err), 256'(e.err));
        pend_strb[d] = e.strobe;
        pend_data[d] = e.wdata;
        pend_idx[d]  = e.idx;
      end
    end else if (err || rd != 32'h0) begin
      chk("idle_outputs", 256'({err, rd}), 256'(0));
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // One transfer, setup at the next rising edge. Returns in the completion
  // cycle with the bus still driven, so consecutive calls are back-to-back.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input bit exp_err, input logic [7:0] exp_strb);
    exp_t e;
    int   n;
    bit   rdy;
    e.rdata = exp_rd; e.err = exp_err; e.strobe = exp_strb;
    e.wdata = wdata;  e.idx = int'(addr[4:2]);
    @(posedge clk); #1;
    psel = 2'b00; psel[d] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wdata;
    last_setup = cyc;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    while (n <= 20) begin
      @(negedge clk);
      rdy = d ? pready1 : pready0;
      if (rdy) break;
      n++;
    end
    chk("wait_cycles", 256'(n), 256'(d ? 3 : 0));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel = 2'b00; penable = 1'b0;
  endtask

  initial begin
    int s;
    rst_n = 1'b0; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs0", 256'({pready0, perr0, prdata0, wrp0}), 256'(0));
    chk("reset_outs1", 256'({pready1, perr1, prdata1, wrp1}), 256'(0));
    chk("reset_regs", regs0 | regs1, 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Zero wait states: write then read back.
    xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 32'h0, 1'b0, 8'h02);
    xfer(0, 1'b0, 32'h04, 32'h0, 32'hDEADBEEF, 1'b0, 8'h00);

    // Back-to-back writes and a read, one transfer every 2 cycles.
    xfer(0, 1'b1, 32'h00, 32'hA0A0A0A0, 32'h0, 1'b0, 8'h01);
    s = last_setup;
    xfer(0, 1'b1, 32'h08, 32'hB1B1B1B1, 32'h0, 1'b0, 8'h04);
    xfer(0, 1'b1, 32'h1C, 32'hC2C2C2C2, 32'h0, 1'b0, 8'h80);
    xfer(0, 1'b0, 32'h1C, 32'h0, 32'hC2C2C2C2, 1'b0, 8'h00);
    chk("b2b_cycles_ws0", 256'(last_setup - s), 256'(6));
    idle();
    chk("regs_ws0", regs0, {32'hC2C2C2C2, 32'h0, 32'h0, 32'h0, 32'h0,
                            32'hB1B1B1B1, 32'hDEADBEEF, 32'hA0A0A0A0});

    // Three wait states.
    xfer(1, 1'b1, 32'h0C, 32'h12345678, 32'h0, 1'b0, 8'h08);
    idle();
    chk("reg3_ws3", 256'(regs1[127:96]), 256'(32'h12345678));

    // Invalid requests: out-of-range and misaligned.
    xfer(1, 1'b1, 32'h20, 32'h99999999, 32'h0, ERR_EN, 8'h00);
    xfer(1, 1'b0, 32'h06, 32'h0, 32'h0, ERR_EN, 8'h00);
    idle();
    chk("regs_after_invalid", regs1, {32'h0, 32'h0, 32'h0, 32'h0,
                                      32'h12345678, 32'h0, 32'h0, 32'h0});

    // Abort: psel drops during the wait states.
    @(posedge clk); #1;
    psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 2'b00; penable = 1'b0;
    repeat (4) @(negedge clk);
    chk("reg0_after_abort", 256'(regs1[31:0]), 256'(0));
    xfer(1, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0, 8'h00);

    // Back-to-back with wait states, one transfer every 5 cycles.
    xfer(1, 1'b1, 32'h10, 32'h11111111, 32'h0, 1'b0, 8'h10);
    s = last_setup;
    xfer(1, 1'b1, 32'h14, 32'h22222222, 32'h0, 1'b0, 8'h20);
    xfer(1, 1'b1, 32'h18, 32'h33333333, 32'h0, 1'b0, 8'h40);
    xfer(1, 1'b0, 32'h10, 32'h0, 32'h11111111, 1'b0, 8'h00);
    chk("b2b_cycles_ws3", 256'(last_setup - s), 256'(15));
    idle();

    // Reset in the middle of an access phase.
    @(posedge clk); #1;
    psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h55555555;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_regs", regs0 | regs1, 256'(0));
    chk("midreset_outs1", 256'({pready1, perr1, prdata1, wrp1}), 256'(0));
    psel = 2'b00; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(1, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0, 8'h00);
    xfer(1, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, 8'h00);
    idle();
    repeat (3) @(negedge clk);
    chk("queues_drained", 256'(q0.size() + q1.size()), 256'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
